// File: rtl/led_stream_pkg.sv
// Shared types for the LED frame streamer: pixel type, stream FSM states
// and the colour sent for pixels beyond the last counted bin.
package led_stream_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEEK = 2'd1,
    EMIT = 2'd2,
    PAD  = 2'd3
  } stream_state_t;

  localparam pixel_t PAD_COLOR = '0;

endpackage

// File: rtl/led_frame_streamer.sv
// Latches one visualizer frame (bin colours and per-bin LED counts) and
// expands it into exactly LEDS pixels over a valid/ready stream. Bins are
// walked in order, each colour repeated by its count; the frame is cut at
// LEDS pixels or padded with PAD_COLOR up to LEDS pixels.
module led_frame_streamer
  import led_stream_pkg::*;
#(
  parameter int LEDS    = 50,
  parameter int BIN_QTY = 12,
  parameter int CW      = $clog2(LEDS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [BIN_QTY-1:0][23:0]    rgb_i,
  input  logic [BIN_QTY-1:0][CW-1:0]  ledCounts_i,
  input  logic                        frameValid_i,
  output logic [23:0]                 pixel_o,
  output logic                        pixelValid_o,
  input  logic                        pixelReady_i,
  output logic                        pixelLast_o,
  output logic                        busy_o,
  output logic                        frameDropped_o
);

  localparam int            BW       = $clog2(BIN_QTY + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LEDS - 1);
  localparam logic [BW-1:0] BIN_END  = BW'(BIN_QTY);

  stream_state_t              r_state;
  logic                       r_fvPrev;
  pixel_t [BIN_QTY-1:0]       r_rgbL;
  logic [BIN_QTY-1:0][CW-1:0] r_countL;
  logic [CW-1:0]              r_ledIdx;
  logic [CW-1:0]              r_remaining;
  logic [BW-1:0]              r_binIdx;
  logic                       r_frameDropped;

  logic                       w_edge;
  logic                       w_valid;
  logic                       w_handshake;
  logic                       w_atLast;
  logic [CW-1:0]              w_binCount;
  pixel_t                     w_binColor;

  assign w_edge      = frameValid_i & ~r_fvPrev;
  assign w_valid     = (r_state == EMIT) || (r_state == PAD);
  assign w_handshake = w_valid & pixelReady_i;
  assign w_atLast    = (r_ledIdx == LAST_IDX);

  // Select the latched count and colour of the current bin; binIdx==BIN_QTY reads as empty.
  always_comb begin
    w_binCount = '0;
    w_binColor = PAD_COLOR;
    for (int b = 0; b < BIN_QTY; b++) begin
      if (r_binIdx == BW'(b)) begin
        w_binCount = r_countL[b];
        w_binColor = r_rgbL[b];
      end
    end
  end

  assign pixel_o        = (r_state == EMIT) ? w_binColor : PAD_COLOR;
  assign pixelValid_o   = w_valid;
  assign pixelLast_o    = w_valid & w_atLast;
  assign busy_o         = (r_state != IDLE);
  assign frameDropped_o = r_frameDropped;

  // Frame FSM: latch on an idle edge, walk the bins, emit/pad until LEDS handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_fvPrev       <= 1'b0;
      r_rgbL         <= '0;
      r_countL       <= '0;
      r_ledIdx       <= '0;
      r_remaining    <= '0;
      r_binIdx       <= '0;
      r_frameDropped <= 1'b0;
    end else begin
      r_fvPrev       <= frameValid_i;
      r_frameDropped <= w_edge && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_edge) begin
            r_rgbL   <= rgb_i;
            r_countL <= ledCounts_i;
            r_binIdx <= '0;
            r_ledIdx <= '0;
            r_state  <= SEEK;
          end
        end
        SEEK: begin
          if (r_binIdx == BIN_END) begin
            r_state <= PAD;
          end else if (w_binCount == '0) begin
            r_binIdx <= r_binIdx + BW'(1);
          end else begin
            r_remaining <= w_binCount;
            r_state     <= EMIT;
          end
        end
        EMIT: begin
          if (w_handshake) begin
            r_ledIdx    <= r_ledIdx + CW'(1);
            r_remaining <= r_remaining - CW'(1);
            if (w_atLast) begin
              r_state <= IDLE;
            end else if (r_remaining == CW'(1)) begin
              r_binIdx <= r_binIdx + BW'(1);
              r_state  <= SEEK;
            end
          end
        end
        PAD: begin
          if (w_handshake) begin
            r_ledIdx <= r_ledIdx + CW'(1);
            if (w_atLast) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_frame_streamer.sv
// Self-checking bench for led_frame_streamer. Expected pixel sequences are
// built from the bin colours and counts (repeat, truncate, pad); handshakes,
// stalls, latency, dropped-frame pulses and reset behaviour are checked.
module tb_led_frame_streamer;
  import led_stream_pkg::*;

  localparam int LEDS    = 50;
  localparam int BIN_QTY = 12;
  localparam int CW      = $clog2(LEDS);
  localparam int BUDGET  = 2000;

  logic                       clk;
  logic                       rst;
  logic [BIN_QTY-1:0][23:0]   rgb_i;
  logic [BIN_QTY-1:0][CW-1:0] ledCounts_i;
  logic                       frameValid_i;
  logic [23:0]                pixel_o;
  logic                       pixelValid_o;
  logic                       pixelReady_i;
  logic                       pixelLast_o;
  logic                       busy_o;
  logic                       frameDropped_o;

  int checks = 0;
  int errors = 0;

  pixel_t expPix [LEDS];
  int     expLat;

  logic [BIN_QTY-1:0][23:0]   rgbA, rgbB, altRgb;
  logic [BIN_QTY-1:0][CW-1:0] cntA, cntB, altCnt;
  int                         idleActivity;

  led_frame_streamer #(.LEDS(LEDS), .BIN_QTY(BIN_QTY), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .rgb_i          (rgb_i),
    .ledCounts_i    (ledCounts_i),
    .frameValid_i   (frameValid_i),
    .pixel_o        (pixel_o),
    .pixelValid_o   (pixelValid_o),
    .pixelReady_i   (pixelReady_i),
    .pixelLast_o    (pixelLast_o),
    .busy_o         (busy_o),
    .frameDropped_o (frameDropped_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Reference: each bin colour repeated by its count, cut at LEDS, zero padded.
  task automatic buildExpected(input logic [BIN_QTY-1:0][23:0] rgb, input logic [BIN_QTY-1:0][CW-1:0] cnt);
    int k = 0;
    int lead = 0;
    bit seenNonZero = 0;
    for (int b = 0; b < BIN_QTY; b++) begin
      if (cnt[b] != 0) seenNonZero = 1;
      else if (!seenNonZero) lead++;
      for (int j = 0; j < int'(cnt[b]); j++) begin
        if (k < LEDS) begin
          expPix[k] = rgb[b];
          k++;
        end
      end
    end
    while (k < LEDS) begin
      expPix[k] = 24'h0;
      k++;
    end
    expLat = 2 + lead;
  endtask

  task automatic randomFrame(output logic [BIN_QTY-1:0][23:0] rgb, output logic [BIN_QTY-1:0][CW-1:0] cnt, input int maxCount);
    for (int b = 0; b < BIN_QTY; b++) begin
      rgb[b] = 24'($urandom);
      cnt[b] = CW'($urandom_range(0, maxCount));
    end
  endtask

  // Present a frame and produce a rising edge; returns just after the edge is sampled.
  task automatic applyStimulus(input logic [BIN_QTY-1:0][23:0] rgb, input logic [BIN_QTY-1:0][CW-1:0] cnt);
    frameValid_i = 1'b0;
    @(negedge clk);
    rgb_i        = rgb;
    ledCounts_i  = cnt;
    frameValid_i = 1'b1;
    buildExpected(rgb, cnt);
    @(negedge clk);
  endtask

  // Consume one frame with random readiness and check it against expPix.
  task automatic collectFrame(input int readyPct, input int fvDropAt, input int reEdgeAt,
                              input int abortAt, input int expDrops);
    int     cyc = 1;
    int     hs = 0;
    int     drops = 0;
    bit     firstSeen = 0;
    bit     stalled = 0;
    bit     reDone = 0;
    bit     done = 0;
    pixel_t heldPix = '0;
    logic   heldLast = 1'b0;
    int     target = (abortAt >= 0) ? abortAt : LEDS;
    while (!done) begin
      if (frameDropped_o) drops++;
      if (cyc == fvDropAt) frameValid_i = 1'b0;
      if (reEdgeAt >= 0 && hs >= reEdgeAt && !reDone && !frameValid_i) begin
        rgb_i        = altRgb;
        ledCounts_i  = altCnt;
        frameValid_i = 1'b1;
        reDone       = 1;
      end
      if (stalled) begin
        checkOutput("stall_valid_hold", pixelValid_o, 1);
        checkOutput("stall_pixel_hold", pixel_o, heldPix);
        checkOutput("stall_last_hold", pixelLast_o, heldLast);
        stalled = 0;
      end
      pixelReady_i = ($urandom_range(0, 99) < readyPct);
      if (pixelValid_o) begin
        if (!firstSeen) begin
          firstSeen = 1;
          checkOutput("first_valid_latency", cyc, expLat);
        end
        if (pixelReady_i) begin
          checkOutput("pixel_value", pixel_o, expPix[hs]);
          checkOutput("pixel_last", pixelLast_o, (hs == LEDS - 1));
          hs++;
        end else begin
          stalled  = 1;
          heldPix  = pixel_o;
          heldLast = pixelLast_o;
        end
      end
      if (hs == target || cyc >= BUDGET) begin
        done = 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("handshake_count", hs, target);
    if (abortAt < 0) begin
      @(negedge clk);
      if (frameDropped_o) drops++;
      checkOutput("end_valid_low", pixelValid_o, 0);
      checkOutput("end_busy_low", busy_o, 0);
      checkOutput("dropped_pulses", drops, expDrops);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid"}, pixelValid_o, 0);
    checkOutput({tag, "_pixel"}, pixel_o, 0);
    checkOutput({tag, "_last"}, pixelLast_o, 0);
    checkOutput({tag, "_busy"}, busy_o, 0);
    checkOutput({tag, "_dropped"}, frameDropped_o, 0);
  endtask

  initial begin
    rst          = 1'b1;
    frameValid_i = 1'b0;
    pixelReady_i = 1'b0;
    rgb_i        = '0;
    ledCounts_i  = '0;
    altRgb       = '0;
    altCnt       = '0;
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    $display("[TB] basic expansion");
    rgbA = '0; cntA = '0;
    rgbA[0] = 24'hFF0000; cntA[0] = CW'(3);
    rgbA[1] = 24'h00FF00; cntA[1] = CW'(2);
    applyStimulus(rgbA, cntA);
    collectFrame(100, 3, -1, -1, 0);

    $display("[TB] zero bins and truncation");
    randomFrame(rgbB, cntB, 9);
    cntB[0] = '0; cntB[1] = '0; cntB[2] = CW'(63); rgbB[2] = 24'h0000FF;
    applyStimulus(rgbB, cntB);
    collectFrame(100, 3, -1, -1, 0);

    $display("[TB] backpressure");
    applyStimulus(rgbA, cntA);
    collectFrame(30, 3, -1, -1, 0);

    $display("[TB] all bins empty");
    randomFrame(rgbB, cntB, 0);
    applyStimulus(rgbB, cntB);
    collectFrame(70, 3, -1, -1, 0);

    $display("[TB] dropped frame");
    randomFrame(rgbA, cntA, 8);
    randomFrame(rgbB, cntB, 8);
    altRgb = rgbB;
    altCnt = cntB;
    applyStimulus(rgbA, cntA);
    collectFrame(60, 1, 15, -1, 1);
    frameValid_i = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("no_frame_after_drop", busy_o, 0);
    applyStimulus(rgbB, cntB);
    collectFrame(100, 3, -1, -1, 0);

    $display("[TB] level hold");
    randomFrame(rgbA, cntA, 9);
    applyStimulus(rgbA, cntA);
    collectFrame(100, -1, -1, -1, 0);
    idleActivity = 0;
    repeat (150) begin
      @(negedge clk);
      if (pixelValid_o || busy_o) idleActivity++;
    end
    checkOutput("level_hold_no_retrigger", idleActivity, 0);
    frameValid_i = 1'b0;

    $display("[TB] reset mid-frame");
    randomFrame(rgbA, cntA, 8);
    applyStimulus(rgbA, cntA);
    collectFrame(100, 3, -1, 20, 0);
    rst = 1'b1;
    @(negedge clk);
    checkAllZero("mid_reset");
    rst = 1'b0;
    applyStimulus(rgbA, cntA);
    collectFrame(100, 3, -1, -1, 0);

    $display("[TB] random frames");
    for (int n = 0; n < 4; n++) begin
      randomFrame(rgbA, cntA, 9);
      applyStimulus(rgbA, cntA);
      collectFrame(int'($urandom_range(20, 100)), 3, -1, -1, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_frame_streamer.md
# led_frame_streamer

Downstream stage of the linear visualizer. Latches the per-bin colours (`rgb`) and LED counts (`LEDCounts`) when the visualizer's `done` rises. Expands them into a serial stream of exactly `LEDS` 24-bit pixels using a valid/ready handshake: each bin's colour repeats `LEDCounts[i]` times, in bin order. A strip-protocol driver sits downstream and consumes the stream.

## Interface
Parameters:
- `LEDS`, 50, number of pixels per frame
- `BIN_QTY`, 12, number of colour bins
- `CW`, `$clog2(LEDS)`, LED-count field width; must equal upstream `LEDCounts` width

Ports:
- `clk`  in  1  single clock domain
- `rst`  in  1  reset, synchronous, active-high
- `rgb_i`  in  `[BIN_QTY][24]`  bin colours, {R,G,B}
- `ledCounts_i`  in  `[BIN_QTY][CW]`  LEDs per bin
- `frameValid_i`  in  1  level; tie to visualizer `done`; only its rising edge matters
- `pixel_o`  out  24  current pixel
- `pixelValid_o`  out  1  `pixel_o` is valid
- `pixelReady_i`  in  1  consumer accepts the pixel
- `pixelLast_o`  out  1  current pixel is pixel index `LEDS-1`
- `busy_o`  out  1  high whenever the state is not IDLE
- `frameDropped_o`  out  1  one-cycle pulse when a frame edge is ignored

## Operation
- **Rising edge.** `fvPrev` is a register of `frameValid_i`. An edge is `frameValid_i & ~fvPrev`.
- **IDLE.** `pixelValid_o=0`. On an edge: latch `rgb_i` and `ledCounts_i` into local registers. Set `binIdx=0` and `ledIdx=0`. Go to SEEK.
- **SEEK.** Takes one cycle per bin examined. `pixelValid_o=0`.
  - If `binIdx==BIN_QTY`, go to PAD.
  - Else if `count[binIdx]==0`, set `binIdx++` and stay in SEEK.
  - Else set `remaining=count[binIdx]` and go to EMIT.
- **EMIT.** `pixel_o=rgbL[binIdx]`, `pixelValid_o=1`. On a handshake (`valid&ready`), `ledIdx++` and `remaining--`, then in priority order:
  - if `ledIdx==LEDS-1`, go to IDLE (the frame is complete and any excess counts are truncated);
  - else if `remaining==1`, set `binIdx++` and go to SEEK.
- **PAD.** Entered when the count sum is below `LEDS`. `pixel_o=24'h0`, `pixelValid_o=1`. On a handshake, `ledIdx++`. If `ledIdx==LEDS-1`, go to IDLE.
- **Last pixel.** `pixelLast_o = pixelValid_o & (ledIdx==LEDS-1)`.
- **Stalling.** While `pixelValid_o=1` and `pixelReady_i=0`, `pixel_o` and `pixelLast_o` hold stable. Valid never drops without a handshake, except on reset.
- **Dropped frames.** An edge seen while not in IDLE sets `frameDropped_o=1` for one cycle. Latched data is unchanged.
- **Exact frame length.** Every accepted frame emits exactly `LEDS` handshakes. The sum of counts is never computed; truncation and padding follow from `ledIdx`.
- **Widths.** `ledIdx` is `CW` bits, `binIdx` is `$clog2(BIN_QTY+1)` bits, `remaining` is `CW` bits.

## Timing
- **Reset values.** All outputs are 0. State is IDLE. `fvPrev`, `ledIdx`, `binIdx`, `remaining` and the latched data are 0.
- **Reset mid-frame.** The frame is aborted. `pixelValid_o=0` on the cycle after `rst` is sampled. No partial frame resumes.
- **Latency.** Edge sampled at posedge N → SEEK from cycle N+1. The first valid pixel appears at N+2 plus one cycle per leading zero-count bin.
- **Bin transitions.** Each transition from one nonzero bin to the next costs 1 SEEK cycle, plus 1 per intervening zero bin. PAD follows the last bin after one SEEK cycle at `binIdx==BIN_QTY`.
- **Simultaneous events.** If the final handshake (return to IDLE) coincides with a new edge, the edge is dropped. The edge is only accepted when the state is IDLE at the sampling posedge.
- **Level input.** `frameValid_i` held high does not retrigger. It must fall and rise again.

## Structure
- Package `led_stream_pkg` contains:
  - `typedef logic [23:0] pixel_t`;
  - `typedef enum logic [1:0] {IDLE, SEEK, EMIT, PAD} stream_state_t`;
  - `localparam pixel_t PAD_COLOR = '0`.
- Single module with no sub-modules. The edge detector is inline (one flop).

## Test plan
- **Basic expansion.** Counts {3,2,0…}, rgb0=FF0000, rgb1=00FF00, ready always 1 → 3×FF0000, 2×00FF00, 45×000000. `pixelLast_o` on the 50th pixel only. First valid at edge+2.
- **Zero bins and truncation.** Counts {0,0,63,…}, rgb2=0000FF → first valid at edge+4. 50×0000FF, then IDLE. No PAD state.
- **Backpressure.** Random `pixelReady_i` with 30% duty → identical pixel sequence to ready=1. `pixel_o` is stable during every stall. Exactly 50 handshakes.
- **Dropped frame.** Second `frameValid_i` edge mid-frame with different data → `frameDropped_o` pulses once. Output stays the first frame. A later edge after IDLE streams the new data.
- **Level hold.** `frameValid_i` held high for 200 cycles → exactly one frame is emitted.
- **Reset mid-frame.** `rst` asserted at pixel 20 → `pixelValid_o=0` the next cycle and all outputs are 0. A new edge after `rst` falls streams a full frame from pixel 0.
